// File: rtl/fpdiv_seq_ctrl_if.sv
// Handshake and datapath-control bundle between the Goldschmidt sequencer and its
// neighbours: requester drives start/abort, the sequencer drives selects and enables.
interface fpdiv_seq_ctrl_if #(
  parameter int CNT_W = 3
);
  logic             start;
  logic             abort;
  logic             sel_mux2;
  logic [1:0]       sel_mux4;
  logic             en_a;
  logic             en_b;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] iter_idx;

  modport master (
    input  start,
    input  abort,
    output sel_mux2,
    output sel_mux4,
    output en_a,
    output en_b,
    output busy,
    output done,
    output iter_idx
  );

  modport slave (
    output start,
    output abort,
    input  sel_mux2,
    input  sel_mux4,
    input  en_a,
    input  en_b,
    input  busy,
    input  done,
    input  iter_idx
  );
endinterface

// File: rtl/fpdiv_seq_ctrl.sv
// Sequencer for the fpdiv Goldschmidt datapath: one initial-approximation pass followed by
// NUM_ITER refinement passes, each pass loading A (numerator) then B (denominator).
module fpdiv_seq_ctrl #(
  parameter int NUM_ITER = 6,
  parameter int CNT_W    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  fpdiv_seq_ctrl_if.master      bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT_N = 3'd1,
    ST_INIT_D = 3'd2,
    ST_ITER_N = 3'd3,
    ST_ITER_D = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ITER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_e           state_r;
  state_e           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;

  logic             sel_mux2_s;
  logic [1:0]       sel_mux4_s;
  logic             en_a_s;
  logic             en_b_s;
  logic             busy_s;
  logic             done_s;
  logic [CNT_W-1:0] iter_idx_s;

  logic             sel_mux2_r;
  logic [1:0]       sel_mux4_r;
  logic             en_a_r;
  logic             en_b_r;
  logic             busy_r;
  logic             done_r;
  logic [CNT_W-1:0] iter_idx_r;

  // State and pass counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state and next-counter logic; abort only acts while busy
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s = ST_INIT_N;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_INIT_N: begin
        if (bus.abort) begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = ST_INIT_D;
        end
      end
      ST_INIT_D: begin
        cnt_s = CNT_ZERO;
        if (bus.abort) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_ITER_N;
        end
      end
      ST_ITER_N: begin
        if (bus.abort) begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = ST_ITER_D;
        end
      end
      ST_ITER_D: begin
        // abort takes priority over finishing the last pass
        if (bus.abort) begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == LAST_IDX) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_ITER_N;
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          state_s = ST_INIT_N;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs track state_r exactly
  always_comb begin
    sel_mux2_s = 1'b0;
    sel_mux4_s = 2'b00;
    en_a_s     = 1'b0;
    en_b_s     = 1'b0;
    busy_s     = 1'b0;
    done_s     = 1'b0;
    iter_idx_s = CNT_ZERO;
    case (state_s)
      ST_IDLE: begin
        busy_s = 1'b0;
      end
      ST_INIT_N: begin
        sel_mux4_s = 2'b00;
        en_a_s     = 1'b1;
        busy_s     = 1'b1;
      end
      ST_INIT_D: begin
        sel_mux4_s = 2'b01;
        en_b_s     = 1'b1;
        busy_s     = 1'b1;
      end
      ST_ITER_N: begin
        sel_mux2_s = 1'b1;
        sel_mux4_s = 2'b10;
        en_a_s     = 1'b1;
        busy_s     = 1'b1;
        iter_idx_s = cnt_s;
      end
      ST_ITER_D: begin
        sel_mux2_s = 1'b1;
        sel_mux4_s = 2'b11;
        en_b_s     = 1'b1;
        busy_s     = 1'b1;
        iter_idx_s = cnt_s;
      end
      ST_DONE: begin
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Output register; reset clears every control line immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_mux2_r <= 1'b0;
      sel_mux4_r <= 2'b00;
      en_a_r     <= 1'b0;
      en_b_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      iter_idx_r <= CNT_ZERO;
    end else begin
      sel_mux2_r <= sel_mux2_s;
      sel_mux4_r <= sel_mux4_s;
      en_a_r     <= en_a_s;
      en_b_r     <= en_b_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      iter_idx_r <= iter_idx_s;
    end
  end

  assign bus.sel_mux2 = sel_mux2_r;
  assign bus.sel_mux4 = sel_mux4_r;
  assign bus.en_a     = en_a_r;
  assign bus.en_b     = en_b_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.iter_idx = iter_idx_r;

endmodule

// File: tb/tb_fpdiv_seq_ctrl.sv
// Bench for fpdiv_seq_ctrl: scenario table plus hand-written reset sequences, with per-cycle
// expected outputs queued as stimulus is planned and popped as each cycle completes.
module tb_fpdiv_seq_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fpdiv_seq_ctrl_if #(.CNT_W(3)) bus6 ();
  fpdiv_seq_ctrl_if #(.CNT_W(3)) bus1 ();

  fpdiv_seq_ctrl #(.NUM_ITER(6), .CNT_W(3)) u_dut6 (.clk(clk), .reset(reset), .bus(bus6));
  fpdiv_seq_ctrl #(.NUM_ITER(1), .CNT_W(3)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

  typedef struct packed {
    logic       sel_mux2;
    logic [1:0] sel_mux4;
    logic       en_a;
    logic       en_b;
    logic       busy;
    logic       done;
    logic [2:0] iter_idx;
  } outs_t;

  typedef struct {
    string name;
    int    dut;       // 0: NUM_ITER=6, 1: NUM_ITER=1
    bit    hold;      // keep start high through the first DONE
    int    pulse_at;  // cycle of an extra start pulse, -1 none
    int    abort_at;  // cycle abort is driven, -1 none
    int    exp_busy;
    int    exp_done;
  } vec_t;

  vec_t  vecs[7];
  outs_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  // Expected outputs per state kind: 0 IDLE, 1 INIT_N, 2 INIT_D, 3 ITER_N, 4 ITER_D, 5 DONE
  function automatic outs_t st_out(int kind, int idx);
    outs_t o;
    o = '0;
    case (kind)
      1: begin o.en_a = 1'b1; o.busy = 1'b1; end
      2: begin o.sel_mux4 = 2'b01; o.en_b = 1'b1; o.busy = 1'b1; end
      3: begin o.sel_mux2 = 1'b1; o.sel_mux4 = 2'b10; o.en_a = 1'b1; o.busy = 1'b1; o.iter_idx = idx[2:0]; end
      4: begin o.sel_mux2 = 1'b1; o.sel_mux4 = 2'b11; o.en_b = 1'b1; o.busy = 1'b1; o.iter_idx = idx[2:0]; end
      5: begin o.done = 1'b1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic outs_t get_outs(int d);
    outs_t o;
    if (d == 1) o = {bus1.sel_mux2, bus1.sel_mux4, bus1.en_a, bus1.en_b, bus1.busy, bus1.done, bus1.iter_idx};
    else        o = {bus6.sel_mux2, bus6.sel_mux4, bus6.en_a, bus6.en_b, bus6.busy, bus6.done, bus6.iter_idx};
    return o;
  endfunction

  task automatic check_outs(string tag, outs_t got, outs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (sel2 sel4 en_a en_b busy done idx)", tag, got, exp);
    end
  endtask

  task automatic check_int(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive inputs of the selected DUT, let the edge pass, compare against the queue
  task automatic tick(input int d, input bit s, input bit a, input string tag, output outs_t got);
    outs_t exp;
    bus6.start = (d == 0) ? s : 1'b0;
    bus6.abort = (d == 0) ? a : 1'b0;
    bus1.start = (d == 1) ? s : 1'b0;
    bus1.abort = (d == 1) ? a : 1'b0;
    @(posedge clk);
    #1;
    got = get_outs(d);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got %b", tag, got);
    end else begin
      exp = exp_q.pop_front();
      check_outs(tag, got, exp);
    end
  endtask

  task automatic push_op(input int n, output int len);
    exp_q.push_back(st_out(1, 0));
    exp_q.push_back(st_out(2, 0));
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(st_out(3, i));
      exp_q.push_back(st_out(4, i));
    end
    exp_q.push_back(st_out(5, 0));
    len = 2 * n + 3;
  endtask

  task automatic run_vec(input vec_t v);
    int    n;
    int    len;
    int    total;
    int    busy_cnt;
    int    done_cnt;
    bit    s;
    bit    a;
    outs_t got;
    n = (v.dut == 1) ? 1 : 6;
    exp_q.delete();
    push_op(n, len);
    if (v.abort_at >= 1) begin
      while (exp_q.size() > v.abort_at) void'(exp_q.pop_back());
    end else if (v.hold) begin
      push_op(n, len);
    end
    exp_q.push_back(st_out(0, 0));
    total    = exp_q.size();
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < total; c++) begin
      s = (c == 0) || (v.hold && c <= len) || (c == v.pulse_at);
      a = (c == v.abort_at);
      tick(v.dut, s, a, v.name, got);
      if (got.busy) busy_cnt++;
      if (got.done) done_cnt++;
    end
    check_int({v.name, "_busy_len"}, busy_cnt, v.exp_busy);
    check_int({v.name, "_done_cnt"}, done_cnt, v.exp_done);
    bus6.start = 1'b0; bus6.abort = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0;
  endtask

  initial begin
    outs_t got;
    vecs[0] = '{"basic6",      0, 1'b0, -1, -1, 14, 1};
    vecs[1] = '{"back2back",   0, 1'b1, -1, -1, 28, 2};
    vecs[2] = '{"start_busy",  0, 1'b0,  5, -1, 14, 1};
    vecs[3] = '{"abort_last",  0, 1'b0, -1, 14, 14, 0};
    vecs[4] = '{"abort_early", 0, 1'b0, -1,  3,  3, 0};
    vecs[5] = '{"start_abort", 0, 1'b0, -1,  0, 14, 1};
    vecs[6] = '{"basic1",      1, 1'b0, -1, -1,  4, 1};

    reset      = 1'b0;
    bus6.start = 1'b0; bus6.abort = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset6", get_outs(0), st_out(0, 0));
    check_outs("reset1", get_outs(1), st_out(0, 0));
    #2 reset = 1'b1;

    exp_q.push_back(st_out(0, 0));
    tick(0, 1'b0, 1'b0, "idle_after_reset", got);
    exp_q.push_back(st_out(0, 0));
    tick(0, 1'b0, 1'b1, "abort_in_idle", got);

    for (int k = 0; k < 7; k++) run_vec(vecs[k]);

    // Reset dropped between edges while in the first ITER_N, then a clean full run
    for (int d = 0; d < 2; d++) begin
      exp_q.delete();
      exp_q.push_back(st_out(1, 0));
      exp_q.push_back(st_out(2, 0));
      exp_q.push_back(st_out(3, 0));
      tick(d, 1'b1, 1'b0, "pre_reset", got);
      tick(d, 1'b0, 1'b0, "pre_reset", got);
      tick(d, 1'b0, 1'b0, "pre_reset", got);
      #3 reset = 1'b0;
      #1;
      check_outs("async_reset", get_outs(d), st_out(0, 0));
      @(posedge clk);
      #1;
      check_outs("held_reset", get_outs(d), st_out(0, 0));
      #2 reset = 1'b1;
      run_vec(vecs[(d == 1) ? 6 : 0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
